fetch_queue: RTL

- Decoupling instruction buffer between the 2-wide fetch stage and decode.
- Accepts up to FETCH_W instructions per cycle from fetch and compacts the valid slots in program order into a circular queue.
- Presents the oldest up to FETCH_W instructions to decode.
- Drives back-pressure to fetch and clears completely on a pipeline flush, e.g. a branch redirect.

---
 rtl/fetch_queue.sv | 106 ++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction buffer that decouples the fetch stage from decode.
// Latency: an enqueued entry becomes visible to decode one cycle after it is written.
//          Entries already stored reach the decode outputs combinationally.
// Backpressure: fetch_stall is driven only from the registered count. It is raised
//          whenever a full fetch group would not fit, and a stalled group is dropped whole.
// Ports:
//   clk, reset (sync active-low), flush                   - control
//   if_valid / if_pc / if_instr                           - fetch group; slot i is at [i*XLEN +: XLEN]
//   fetch_stall                                           - back-pressure to fetch
//   dq_valid / dq_pc / dq_instr / dq_ready                - decode side; slot0 is the oldest entry
//   occupancy                                             - current entry count
module fetch_queue #(
   parameter int XLEN    = 32,
   parameter int FETCH_W = 2,
   parameter int DEPTH   = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush,
   input  logic [FETCH_W-1:0]      if_valid,
   input  logic [FETCH_W*XLEN-1:0] if_pc,
   input  logic [FETCH_W*XLEN-1:0] if_instr,
   output logic                    fetch_stall,
   output logic [FETCH_W-1:0]      dq_valid,
   output logic [FETCH_W*XLEN-1:0] dq_pc,
   output logic [FETCH_W*XLEN-1:0] dq_instr,
   input  logic                    dq_ready,
   output logic [$clog2(DEPTH):0]  occupancy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] FW_C    = CW'(FETCH_W);

   logic [XLEN-1:0] pc_mem    [DEPTH];
   logic [XLEN-1:0] instr_mem [DEPTH];

   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] count;

   logic [CW-1:0] n_enq;
   logic [CW-1:0] n_deq;
   logic [CW-1:0] enq_amt;
   logic [CW-1:0] deq_amt;
   logic [AW-1:0] enq_off [FETCH_W];

   assign occupancy   = count;
   assign fetch_stall = (DEPTH_C - count) < FW_C;

   // Compaction: each valid slot's write offset is the number of valid
   // slots below it, so the valid slots land contiguously in slot order.
   always_comb begin
      n_enq = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         enq_off[i] = n_enq[AW-1:0];
         n_enq      = n_enq + CW'(if_valid[i]);
      end
   end

   always_comb begin
      n_deq    = '0;
      dq_valid = '0;
      dq_pc    = '0;
      dq_instr = '0;
      for (int i = 0; i < FETCH_W; i++) begin
         dq_valid[i]                = count > CW'(i);
         dq_pc[i*XLEN +: XLEN]      = pc_mem[head + AW'(i)];
         dq_instr[i*XLEN +: XLEN]   = instr_mem[head + AW'(i)];
         n_deq                      = n_deq + CW'(dq_valid[i]);
      end
   end

   assign enq_amt = fetch_stall ? '0 : n_enq;
   assign deq_amt = dq_ready ? n_deq : '0;

   always_ff @(posedge clk) begin
      if (!reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + deq_amt[AW-1:0];
         tail  <= tail + enq_amt[AW-1:0];
         count <= count + enq_amt - deq_amt;
      end
   end

   // Storage is not reset. Entries outside head..tail are never presented as valid.
   always_ff @(posedge clk) begin
      if (reset && !flush && !fetch_stall) begin
         for (int i = 0; i < FETCH_W; i++) begin
            if (if_valid[i]) begin
               pc_mem[tail + enq_off[i]]    <= if_pc[i*XLEN +: XLEN];
               instr_mem[tail + enq_off[i]] <= if_instr[i*XLEN +: XLEN];
            end
         end
      end
   end

   a_count_max : assert property (@(posedge clk) disable iff (!reset) count <= DEPTH_C);
   a_ptr_count : assert property (@(posedge clk) disable iff (!reset)
                                  (tail - head) == count[AW-1:0]);

endmodule
